dbu_scan_ctrl: RTL and testbench

- Parametrised debug-unit core that sits between the board I/O and the CPU.
- Replaces the gated run clock with a clock-enable (`cpu_en`).
- Debounces and edge-detects the `step`/`inc`/`dec` buttons, keeps a wrapping memory/RF address counter, and selects the debug word.
- Drives a time-multiplexed 7-segment display with a configurable digit count, an internal hex decoder and tear-free frame capture.

---
 rtl/dbu_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_dbu_scan_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dbu_scan_ctrl.sv
// dbu_scan_ctrl: debug-unit core providing CPU run control, button
// conditioning, a debug address counter and a scanned 7-segment display.
//   clk, rst             clock, asynchronous active-high reset
//   succ                 1 = continuous run, 0 = single-step
//   step, inc, dec       raw buttons (synchronised and debounced here)
//   m_rf, sel            debug word select
//   m_data, rf_data      memory / register-file word at m_rf_addr
//   data                 CPU internal word chosen by sel
//   cpu_en               CPU clock enable
//   m_rf_addr            debug read address
//   halted               breakpoint halt flag
//   SSEG_CA, SSEG_AN     active-low segments (bit0=a..bit6=g, bit7=dp) and anodes
// Define BREAKPOINT_EN to add pc, bp_addr and bp_valid plus the breakpoint halt.
module dbu_scan_ctrl #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 16,
   parameter int DB_LEN   = 16
) (
   input  logic              clk,
   input  logic              rst,
`ifdef BREAKPOINT_EN
   input  logic [DATA_W-1:0] pc,
   input  logic [DATA_W-1:0] bp_addr,
   input  logic              bp_valid,
`endif
   input  logic              succ,
   input  logic              step,
   input  logic              inc,
   input  logic              dec,
   input  logic              m_rf,
   input  logic [2:0]        sel,
   input  logic [DATA_W-1:0] m_data,
   input  logic [DATA_W-1:0] rf_data,
   input  logic [DATA_W-1:0] data,
   output logic              cpu_en,
   output logic [ADDR_W-1:0] m_rf_addr,
   output logic              halted,
   output logic [7:0]        SSEG_CA,
   output logic [DIGITS-1:0] SSEG_AN
);
   localparam int DBW = $clog2(DB_LEN);
   localparam int KW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW  = KW + SCAN_DIV;
   localparam logic [CW-1:0] LAST = CW'(DIGITS * (2 ** SCAN_DIV) - 1);
   logic [2:0] btn, pulse;
   logic step_p, inc_p, dec_p;
   assign btn = {dec, inc, step};
   assign {dec_p, inc_p, step_p} = pulse;
   // Per button: 2-FF synchroniser, stability counter, registered rising-edge pulse.
   for (genvar b = 0; b < 3; b++) begin : g_btn
      logic s0, s1, lvl, prv, pl;
      logic [DBW-1:0] dc;
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            {s0, s1, lvl, prv, pl} <= '0;
            dc <= '0;
         end else begin
            s0 <= btn[b];
            s1 <= s0;
            prv <= lvl;
            pl <= lvl & ~prv;
            if (s1 == lvl) dc <= '0;
            else if (dc == DBW'(DB_LEN - 1)) begin
               lvl <= s1;
               dc <= '0;
            end else dc <= dc + 1'b1;
         end
      assign pulse[b] = pl;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) m_rf_addr <= '0;
      else if (inc_p != dec_p) m_rf_addr <= inc_p ? m_rf_addr + 1'b1 : m_rf_addr - 1'b1;
`ifdef BREAKPOINT_EN
   logic hlt, skip, match;
   // skip masks the breakpoint after a step-out until pc leaves bp_addr.
   assign match = succ & bp_valid & (pc == bp_addr) & ~skip;
   assign halted = hlt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cpu_en <= 1'b0;
         hlt <= 1'b0;
         skip <= 1'b0;
      end else if (hlt) begin
         hlt <= succ & ~step_p;
         cpu_en <= step_p;
         skip <= step_p;
      end else begin
         skip <= skip & (pc == bp_addr);
         hlt <= match;
         cpu_en <= ~match & (succ | step_p);
      end
`else
   assign halted = 1'b0;
   always_ff @(posedge clk or posedge rst)
      if (rst) cpu_en <= 1'b0;
      else cpu_en <= succ | step_p;
`endif
   logic [DATA_W-1:0] dword, dreg;
   logic [CW-1:0] cnt;
   logic [KW-1:0] dig;
   assign dword = (sel == 3'd0) ? (m_rf ? m_data : rf_data) : data;
   assign dig = cnt[CW-1:SCAN_DIV];
   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'hC0;
         4'h1: hex7 = 8'hF9;
         4'h2: hex7 = 8'hA4;
         4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;
         4'h5: hex7 = 8'h92;
         4'h6: hex7 = 8'h82;
         4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;
         4'h9: hex7 = 8'h90;
         4'hA: hex7 = 8'h88;
         4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;
         4'hD: hex7 = 8'hA1;
         4'hE: hex7 = 8'h86;
         default: hex7 = 8'h8E;
      endcase
   endfunction
   // The display word is latched only at frame wrap so every digit of a frame shows one value.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         dreg <= '0;
         SSEG_CA <= 8'hFF;
         SSEG_AN <= '1;
      end else begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
         if (cnt == LAST) dreg <= dword;
         SSEG_AN <= ~(DIGITS'(1) << dig);
         SSEG_CA <= hex7(dreg[{dig, 2'b00} +: 4]);
      end
endmodule

// File: tb/tb_dbu_scan_ctrl.sv
// tb_dbu_scan_ctrl: directed self-checking bench for dbu_scan_ctrl.
module tb_dbu_scan_ctrl;
   logic clk = 0, rst = 0, succ = 0, step = 0, inc = 0, dec = 0, m_rf = 1;
   logic [2:0] sel = 3'd0;
   logic [31:0] m_data = 32'h1234ABCD, rf_data = 32'h55555555, data = 32'hFFFFFFFF;
   logic [31:0] pc = 32'h8, bp_addr = 32'h10;
   logic bp_valid = 0;
   logic cpu_en, halted, cpu_en5, halted5;
   logic [8:0] addr, addr5;
   logic [7:0] ca, an, ca5;
   logic [4:0] an5;
   logic [7:0] exp_ca [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
   int n_cmp = 0, n_err = 0, en_cnt = 0, en_run = 0, en_max = 0;
   always #5 clk = ~clk;
   dbu_scan_ctrl #(.ADDR_W(9), .DATA_W(32), .DIGITS(8), .SCAN_DIV(2), .DB_LEN(4)) u_dut (
      .clk(clk), .rst(rst),
`ifdef BREAKPOINT_EN
      .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
`endif
      .succ(succ), .step(step), .inc(inc), .dec(dec), .m_rf(m_rf), .sel(sel),
      .m_data(m_data), .rf_data(rf_data), .data(data), .cpu_en(cpu_en),
      .m_rf_addr(addr), .halted(halted), .SSEG_CA(ca), .SSEG_AN(an));
   dbu_scan_ctrl #(.ADDR_W(9), .DATA_W(32), .DIGITS(5), .SCAN_DIV(1), .DB_LEN(4)) u_dut5 (
      .clk(clk), .rst(rst),
`ifdef BREAKPOINT_EN
      .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
`endif
      .succ(succ), .step(step), .inc(inc), .dec(dec), .m_rf(m_rf), .sel(sel),
      .m_data(m_data), .rf_data(rf_data), .data(data), .cpu_en(cpu_en5),
      .m_rf_addr(addr5), .halted(halted5), .SSEG_CA(ca5), .SSEG_AN(an5));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
      if (cpu_en) begin
         en_cnt++;
         en_run++;
         if (en_run > en_max) en_max = en_run;
      end else en_run = 0;
   endtask
   task automatic press(input int which, input int hold);
      {dec, inc, step} = 3'b001 << which;
      repeat (hold) tick();
      {dec, inc, step} = 3'b000;
      repeat (12) tick();
   endtask
   initial begin
      #2 rst = 1;
      repeat (3) tick();
      chk("rst_an", an, 8'hFF);
      chk("rst_ca", ca, 8'hFF);
      chk("rst_an5", an5, 5'h1F);
      chk("rst_en", cpu_en, 0);
      chk("rst_addr", addr, 0);
      chk("rst_halt", halted, 0);
      rst = 0;
      for (int i = 0; i < 32; i++) begin
         tick();
         chk("an8", an, 8'(~(8'd1 << (i / 4))));
         chk("an5", an5, 5'(~(5'd1 << ((i / 2) % 5))));
         if (i == 0) chk("ca_frame0", ca, 8'hC0);
      end
      for (int i = 0; i < 32; i++) begin
         tick();
         if (i % 4 == 0) chk("ca_digit", ca, exp_ca[i / 4]);
         if (i == 8) m_data = 32'h0;
      end
      tick();
      chk("ca_newframe", ca, 8'hC0);
      inc = 1;
      tick();
      inc = 0;
      repeat (15) tick();
      chk("glitch", addr, 9'h000);
      press(1, 100);
      chk("inc", addr, 9'h001);
      press(2, 10);
      chk("dec_to0", addr, 9'h000);
      press(2, 10);
      chk("dec_wrap", addr, 9'h1FF);
      press(2, 10);
      chk("dec_1fe", addr, 9'h1FE);
      {inc, dec} = 2'b11;
      repeat (10) tick();
      {inc, dec} = 2'b00;
      repeat (12) tick();
      chk("inc_dec", addr, 9'h1FE);
      press(1, 10);
      press(1, 10);
      chk("inc_wrap", addr, 9'h000);
      chk("idle_en", en_cnt, 0);
      step = 1;
      repeat (7) tick();
      chk("step_early", cpu_en, 0);
      tick();
      chk("step_pulse", cpu_en, 1);
      tick();
      chk("step_end", cpu_en, 0);
      tick();
      step = 0;
      repeat (12) tick();
      press(0, 30);
      press(0, 8);
      chk("step_cnt", en_cnt, 3);
      chk("step_width", en_max, 1);
      succ = 1;
      tick();
      chk("run_en", cpu_en, 1);
      en_cnt = 0;
      press(0, 10);
      chk("run_cnt", en_cnt, 22);
      rst = 1;
      #1;
      chk("rst_mid_en", cpu_en, 0);
      chk("rst_mid_an", an, 8'hFF);
`ifdef BREAKPOINT_EN
      bp_valid = 1;
      pc = 32'h08;
      tick();
      rst = 0;
      tick();
      chk("bp_run", cpu_en, 1);
      pc = 32'h0C;
      tick();
      chk("bp_nohalt", halted, 0);
      pc = 32'h10;
      tick();
      chk("bp_halt", halted, 1);
      chk("bp_en0", cpu_en, 0);
      tick();
      chk("bp_hold", halted, 1);
      step = 1;
      repeat (7) tick();
      chk("bp_wait", halted, 1);
      chk("bp_wait_en", cpu_en, 0);
      tick();
      chk("bp_stepout", halted, 0);
      chk("bp_step_en", cpu_en, 1);
      step = 0;
      tick();
      chk("bp_skip", halted, 0);
      pc = 32'h14;
      tick();
      pc = 32'h10;
      tick();
      chk("bp_rehalt", halted, 1);
      succ = 0;
      tick();
      chk("bp_succ0", halted, 0);
`else
      tick();
      rst = 0;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
